mips_fetch_stage: RTL and testbench

//  Instruction-fetch front end of the mips core: owns the fetch PC, issues requests to instruction memory,

---
 rtl/mips_fetch_pkg.sv | 12 +
 rtl/mips_fetch_stage_fifo.sv | 50 +++++
 rtl/mips_fetch_stage.sv | 109 ++++++++++
 tb/tb_mips_fetch_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared constants and the {pc,instr} entry type for the fetch front end.
package mips_fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_STEP  = 32'd4;
    localparam logic [INSTR_W-1:0] NOP      = 32'h0000_0000;
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/mips_fetch_stage_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush; push is taken when full only alongside a pop.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_din,
    input  logic                   i_pop,
    output fetch_entry_t           o_dout,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign w_pop   = i_pop && r_count != '0;
    assign w_push  = i_push && (r_count != FULL || w_pop);
    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end
endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: owns the fetch PC, issues credit-limited imem requests, pairs responses with
// their PCs and presents {pc,instr} to decode; redirects flush the buffers and drop stale responses.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = mips_fetch_pkg::RESET_PC,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready,
    output logic [31:0] pc
);
    import mips_fetch_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;

    logic          r_run;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] w_qcnt;
    logic [CW-1:0] w_icnt;
    fetch_entry_t  w_req;
    fetch_entry_t  w_infl;
    fetch_entry_t  w_qin;
    fetch_entry_t  w_qhead;
    logic          w_pop;
    logic          w_acc;
    logic          w_resp;
    logic          w_keep;
    logic          w_credit;

    // Outstanding requests (stale ones included) plus buffered entries never exceed QDEPTH.
    assign w_pop    = if_valid && id_ready;
    assign w_credit = {1'b0, r_out} + {1'b0, w_qcnt} - (CW+1)'(w_pop) < (CW+1)'(QDEPTH);
    assign imem_req  = r_run && !redirect_valid && w_credit;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign w_acc  = imem_req && imem_ready;
    assign w_resp = imem_rvalid && r_out != '0;
    assign w_keep = w_resp && r_drop == '0;
    assign w_req  = '{pc: r_pc, instr: NOP};

    assign if_valid = w_qcnt != '0;
    assign if_pc    = if_valid ? w_qhead.pc : '0;
    assign if_instr = if_valid ? w_qhead.instr : '0;

    always_comb begin
        w_qin       = w_infl;
        w_qin.instr = imem_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run  <= 1'b0;
            r_pc   <= RESET_PC;
            r_out  <= '0;
            r_drop <= '0;
        end else begin
            r_run <= 1'b1;
            r_out <= r_out + CW'(w_acc) - CW'(w_resp);
            if (redirect_valid) begin
                r_pc   <= redirect_pc & ~32'h3;
                r_drop <= r_out - CW'(w_resp);
            end else begin
                r_pc   <= w_acc ? r_pc + PC_STEP : r_pc;
                r_drop <= (w_resp && r_drop != '0) ? r_drop - CW'(1) : r_drop;
            end
        end
    end

    fetch_fifo #(.DEPTH(QDEPTH)) u_inflight (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_acc),
        .i_din   (w_req),
        .i_pop   (w_keep),
        .o_dout  (w_infl),
        .o_count (w_icnt)
    );

    fetch_fifo #(.DEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_keep),
        .i_din   (w_qin),
        .i_pop   (w_pop),
        .o_dout  (w_qhead),
        .o_count (w_qcnt)
    );

    always @(posedge clk) begin
        if (reset) begin
            assert (!(imem_rvalid && r_out == '0));
            assert (w_icnt == r_out - r_drop);
        end
    end
endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb_mips_fetch_stage: random/directed stimulus against a queue-based model of the fetch stage.
module tb_mips_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready = 1'b0;
    logic [31:0] pc;

    mips_fetch_stage dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready), .pc(pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rdy_pct = 100;
    int          idr_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          redir_req = 1'b0;
    logic [31:0] redir_tgt = '0;
    req_t        memq[$];
    logic [31:0] m_buf[$];
    logic [31:0] m_pc = '0;
    int          m_drop = 0;
    bit          m_run = 1'b0;
    logic [31:0] pop_pc[$];
    int          pop_cyc[$];
    int          acc_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit roll(input int p);
        return p >= 100 || int'($urandom_range(0, 99)) < p;
    endfunction

    function automatic logic [31:0] pp(input int i);
        return i < pop_pc.size() ? pop_pc[i] : 'x;
    endfunction

    function automatic int pc_at(input int i);
        return i < pop_cyc.size() ? pop_cyc[i] : -1;
    endfunction

    task automatic clear_logs();
        pop_pc.delete();
        pop_cyc.delete();
        acc_cyc.delete();
    endtask

    // Memory returns the request address as the instruction word, in order, after a random latency.
    task automatic model_cycle();
        bit          pop;
        bit          ereq;
        bit          acc;
        req_t        r;
        logic [31:0] head;
        pop  = m_buf.size() != 0 && id_ready;
        ereq = m_run && !redirect_valid && (memq.size() + m_buf.size() - int'(pop) < 4);
        head = m_buf.size() != 0 ? m_buf[0] : 32'h0;
        chk("imem_req", 32'(imem_req), 32'(ereq));
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_buf.size() != 0));
        chk("if_pc", if_pc, head);
        chk("if_instr", if_instr, head);
        acc   = ereq && imem_ready;
        m_run = 1'b1;
        if (pop) begin
            pop_pc.push_back(m_buf.pop_front());
            pop_cyc.push_back(cyc);
        end
        if (imem_rvalid) begin
            r = memq.pop_front();
            if (m_drop > 0) m_drop--;
            else m_buf.push_back(r.addr);
        end
        if (redirect_valid) begin
            m_buf.delete();
            m_drop = memq.size();
            m_pc   = redirect_pc & ~32'h3;
        end else if (acc) begin
            r.addr = m_pc;
            r.due  = cyc + int'($urandom_range(lat_min, lat_max));
            memq.push_back(r);
            acc_cyc.push_back(cyc);
            m_pc += 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        imem_rvalid = memq.size() != 0 && memq[0].due <= cyc;
        if (imem_rvalid) imem_rdata = memq[0].addr;
        else imem_rdata = $urandom;
        imem_ready     = roll(rdy_pct);
        id_ready       = roll(idr_pct);
        redirect_valid = redir_req;
        redirect_pc    = redir_tgt;
        redir_req      = 1'b0;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // A response still owed by memory is delivered while reset is low and must vanish.
    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_rvalid    = memq.size() != 0;
        imem_rdata     = 32'hDEAD_BEEF;
        #1;
        chk("rst if_valid", 32'(if_valid), 32'h0);
        chk("rst pc", pc, 32'h0);
        chk("rst imem_req", 32'(imem_req), 32'h0);
        chk("rst if_pc", if_pc, 32'h0);
        chk("rst if_instr", if_instr, 32'h0);
        memq.delete();
        m_buf.delete();
        m_drop = 0;
        m_run  = 1'b0;
        m_pc   = 32'h0;
        @(posedge clk);
        #1 imem_rvalid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rel imem_req", 32'(imem_req), 32'h0);
        m_run = 1'b1;
    endtask

    initial begin
        #3;
        do_reset();
        clear_logs();
        step();
        chk("t1 pc", pc, 32'h0);
        chk("t1 imem_req", 32'(imem_req), 32'h1);
        chk("t1 imem_addr", imem_addr, 32'h0);
        chk("t1 if_valid", 32'(if_valid), 32'h0);
        run(7);
        chk("t2 pop0", pp(0), 32'h0);
        chk("t2 pop1", pp(1), 32'h4);
        chk("t2 pop2", pp(2), 32'h8);
        chk("t2 pop3", pp(3), 32'hC);
        chk("t2 fill", 32'(pc_at(0) - acc_cyc[0]), 32'd2);
        chk("t2 back2back", 32'(pc_at(3) - pc_at(0)), 32'd3);

        do_reset();
        idr_pct = 0;
        run(10);
        chk("t3 imem_req", 32'(imem_req), 32'h0);
        chk("t3 imem_addr", imem_addr, 32'h10);
        chk("t3 if_pc", if_pc, 32'h0);
        chk("t3 held", 32'(m_buf.size()), 32'd4);
        idr_pct = 100;
        clear_logs();
        run(6);
        chk("t3 drain0", pp(0), 32'h0);
        chk("t3 drain3", pp(3), 32'hC);
        chk("t3 resume", pp(4), 32'h10);

        do_reset();
        lat_min = 2;
        lat_max = 2;
        run(6);
        chk("t4 outstanding", 32'(memq.size()), 32'd2);
        redir_req = 1'b1;
        redir_tgt = 32'h103;
        step();
        clear_logs();
        step();
        chk("t4 imem_addr", imem_addr, 32'h100);
        run(8);
        chk("t4 first", pp(0), 32'h100);
        chk("t4 second", pp(1), 32'h104);

        lat_min = 1;
        lat_max = 1;
        redir_req = 1'b1;
        redir_tgt = 32'hFFFF_FFF8;
        step();
        clear_logs();
        run(8);
        chk("t5 wrap0", pp(0), 32'hFFFF_FFF8);
        chk("t5 wrap1", pp(1), 32'hFFFF_FFFC);
        chk("t5 wrap2", pp(2), 32'h0);

        lat_min = 3;
        lat_max = 3;
        run(8);
        chk("t6 inflight", 32'(memq.size()), 32'd3);
        do_reset();
        lat_min = 1;
        lat_max = 1;
        clear_logs();
        run(6);
        chk("t6 first", pp(0), 32'h0);

        rdy_pct = 70;
        idr_pct = 70;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if (roll(3)) begin
                redir_req = 1'b1;
                redir_tgt = roll(25) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            end
            step();
        end
        rdy_pct = 100;
        idr_pct = 100;
        run(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
